// File: rtl/aemb_dwb_pkg.sv
// Shared definitions for the aeMB data-bus RAM responder: state encoding,
// big-endian lane mapping and wait-state limit.
package aemb_dwb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dwb_state_e;

  // sel bit / write-enable lane that carries each big-endian byte offset
  localparam int LANE_OFS0 = 3;
  localparam int LANE_OFS1 = 2;
  localparam int LANE_OFS2 = 1;
  localparam int LANE_OFS3 = 0;

  localparam int WAIT_MAX = 15;

endpackage

// File: rtl/aemb_dwb_bram.sv
// Byte-lane write, synchronous-read word array; lane i covers bits [8i+7:8i].
module aemb_dwb_bram #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-3:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**(AW-2)];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/aemb_dwb_ram.sv
// aeMB data Wishbone slave: request capture, programmable wait states,
// registered ack and read-data hold around a swappable byte-write RAM.
module aemb_dwb_ram
  import aemb_dwb_pkg::*;
#(
  parameter int AW   = 16,
  parameter int WAIT = 0
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [AW-1:2] dwb_adr_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o
);

  localparam int         WAIT_C    = (WAIT > WAIT_MAX) ? WAIT_MAX : WAIT;
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_C > 0) ? WAIT_C - 1 : 0);

  dwb_state_e    state_q, state_d;
  logic [3:0]    cnt_q;
  logic          ack_q;
  logic [31:0]   hold_q;
  logic [AW-1:2] adr_q;
  logic [3:0]    sel_q;
  logic          wre_q;
  logic [31:0]   dat_q;

  logic          idle, enter_ack, cmd_wre;
  logic [3:0]    cmd_sel, ram_we;
  logic [AW-1:2] ram_adr;
  logic [31:0]   ram_wdat, ram_rdat;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (dwb_stb_i) state_d = (WAIT_C == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        if (!dwb_stb_i)              state_d = ST_IDLE;
        else if (cnt_q == WAIT_LAST) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With no wait states the RAM must see the live request on the sampling edge.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    ram_adr   = idle ? dwb_adr_i : adr_q;
    cmd_sel   = idle ? dwb_sel_i : sel_q;
    cmd_wre   = idle ? dwb_wre_i : wre_q;
    ram_wdat  = idle ? dwb_dat_i : dat_q;
    enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK) && !sys_rst_i;
    ram_we    = (enter_ack && cmd_wre) ? cmd_sel : 4'b0000;
    dwb_dat_o = (state_q == ST_ACK && !wre_q) ? ram_rdat : hold_q;
    dwb_ack_o = ack_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ST_ACK);
      if (state_d != ST_WAIT)
        cnt_q <= 4'd0;
      else if (state_q == ST_WAIT && cnt_q != WAIT_LAST)
        cnt_q <= cnt_q + 4'd1;
      if (state_q == ST_ACK && !wre_q)
        hold_q <= ram_rdat;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (idle && dwb_stb_i) begin
      adr_q <= dwb_adr_i;
      sel_q <= dwb_sel_i;
      wre_q <= dwb_wre_i;
      dat_q <= dwb_dat_i;
    end
  end

  aemb_dwb_bram #(.AW(AW)) u_bram (
    .clk   (sys_clk_i),
    .we    (ram_we),
    .addr  (ram_adr),
    .wdata (ram_wdat),
    .rdata (ram_rdat)
  );

endmodule
